mult16_share_sched: RTL

//  Shares one pipelined 16x16 compressor-tree multiplier (Comp_Mult16) among NUM_REQ requesters.

---
 rtl/mult16_share_sched_pkg.sv | 21 ++
 rtl/mult16_share_sched_if.sv | 28 ++
 rtl/mult16_share_sched_comp.sv | 33 +++
 rtl/mult16_share_sched_pp_gen.sv | 26 ++
 rtl/mult16_share_sched.sv | 119 +++++++++++
 5 files changed

// File: rtl/mult16_share_sched_pkg.sv
// Shared types and constants for the time-shared 16x16 multiplier scheduler.
package mult16_sched_pkg;

  localparam int unsigned OP_W     = 16;
  localparam int unsigned PROD_W   = 32;
  localparam int unsigned NCOL     = 31;
  localparam int unsigned ID_MAX_W = 8;

  // Each column is padded to OP_W bits; bits at or above col_h(k) are always zero.
  typedef logic [NCOL-1:0][OP_W-1:0] cols_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [PROD_W-1:0]   product;
  } rsp_t;

  function automatic int unsigned col_h(input int unsigned k);
    return (k < OP_W) ? k + 1 : NCOL - k;
  endfunction

endpackage

// File: rtl/mult16_share_sched_if.sv
// Requester/consumer bundle for mult16_share_sched; the scheduler is the slave side.
interface mult16_share_sched_if
  import mult16_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) ();
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0][OP_W-1:0] req_a;
  logic [NUM_REQ-1:0][OP_W-1:0] req_b;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_W-1:0]              rsp_id;
  logic [PROD_W-1:0]            rsp_product;
  logic                         busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product, busy
  );
endinterface

// File: rtl/mult16_share_sched_comp.sv
// Behavioural stand-in for the shared compressor-tree multiplier: no reset, PIPE_LAT edges deep.
module Comp_Mult16
  import mult16_sched_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic              clk,
  input  cols_t             in_col,
  output logic [PROD_W-1:0] comp_out
);
  localparam int unsigned CI_W = $clog2(NCOL);
  localparam int unsigned PL_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  logic [PROD_W-1:0] w_sum;
  logic [PROD_W-1:0] r_pipe [PIPE_LAT];

  always_comb begin
    w_sum = '0;
    for (int unsigned k = 0; k < NCOL; k++) begin
      w_sum = w_sum + (PROD_W'($countones(in_col[CI_W'(k)])) << k);
    end
  end

  always_ff @(posedge clk) begin
    r_pipe[0] <= w_sum;
    for (int unsigned s = 1; s < PIPE_LAT; s++) begin
      r_pipe[PL_W'(s)] <= r_pipe[PL_W'(s - 1)];
    end
  end

  assign comp_out = r_pipe[PL_W'(PIPE_LAT - 1)];

endmodule

// File: rtl/mult16_share_sched_pp_gen.sv
// Partial-product column builder: column k gathers a[i]&b[j] for every i+j=k.
module mult16_pp_gen
  import mult16_sched_pkg::*;
(
  input  logic [OP_W-1:0] i_a,
  input  logic [OP_W-1:0] i_b,
  output cols_t           o_cols
);
  localparam int unsigned CI_W = $clog2(NCOL);
  localparam int unsigned BI_W = $clog2(OP_W);

  // Slot s of column k holds i = lo+s, where lo is the smallest legal i for that column.
  always_comb begin
    o_cols = '0;
    for (int unsigned k = 0; k < NCOL; k++) begin
      for (int unsigned s = 0; s < OP_W; s++) begin
        if (s < col_h(k)) begin
          o_cols[CI_W'(k)][BI_W'(s)] =
            i_a[BI_W'(((k < OP_W) ? 0 : k - OP_W + 1) + s)] &
            i_b[BI_W'(k - ((k < OP_W) ? 0 : k - OP_W + 1) - s)];
        end
      end
    end
  end

endmodule

// File: rtl/mult16_share_sched.sv
// Round-robin scheduler sharing one pipelined Comp_Mult16 among NUM_REQ requesters,
// with an in-order, credit-guarded FWFT result FIFO.
module mult16_share_sched
  import mult16_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned PIPE_LAT   = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  mult16_share_sched_if.slave bus
);
  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]              r_ptr;
  logic [ID_W-1:0]              w_gnt_id;
  logic                         w_gnt_found;
  logic                         w_credit_ok;
  logic                         w_issue;
  logic                         w_pop;
  logic                         w_push;
  logic [CNT_W-1:0]             r_cnt;
  logic [OP_W-1:0]              r_a;
  logic [OP_W-1:0]              r_b;
  logic [PIPE_LAT:0]            r_tag_v;
  logic [PIPE_LAT:0][ID_W-1:0]  r_tag_id;
  cols_t                        w_cols;
  logic [PROD_W-1:0]            w_comp;
  rsp_t                         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             r_wr;
  logic [PTR_W-1:0]             r_rd;
  logic [CNT_W-1:0]             r_fill;

  // Search from r_ptr upward; the sum stays below 2*NUM_REQ so one subtraction wraps it.
  always_comb begin
    logic [ID_W:0] v_sum;
    v_sum       = '0;
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      v_sum = {1'b0, r_ptr} + (ID_W+1)'(off);
      if (v_sum >= (ID_W+1)'(NUM_REQ)) v_sum = v_sum - (ID_W+1)'(NUM_REQ);
      if (!w_gnt_found && bus.req_valid[v_sum[ID_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = v_sum[ID_W-1:0];
      end
    end
  end

  assign w_credit_ok = (r_cnt < CNT_W'(FIFO_DEPTH));
  assign w_issue     = rst_n & w_gnt_found & w_credit_ok;
  assign w_pop       = bus.rsp_valid & bus.rsp_ready;
  assign w_push      = r_tag_v[PIPE_LAT];

  always_comb begin
    bus.req_ready = '0;
    if (w_issue) bus.req_ready[w_gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      if (w_issue) begin
        r_ptr <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
        r_a   <= bus.req_a[w_gnt_id];
        r_b   <= bus.req_b[w_gnt_id];
      end
      r_tag_v  <= {r_tag_v[PIPE_LAT-1:0], w_issue};
      r_tag_id <= {r_tag_id[PIPE_LAT-1:0], w_gnt_id};
      if (w_issue && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_issue && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  mult16_pp_gen u_pp_gen (
    .i_a    (r_a),
    .i_b    (r_b),
    .o_cols (w_cols)
  );

  Comp_Mult16 #(.PIPE_LAT(PIPE_LAT)) u_comp (
    .clk      (clk),
    .in_col   (w_cols),
    .comp_out (w_comp)
  );

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= '{id: ID_MAX_W'(r_tag_id[PIPE_LAT]), product: w_comp};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd + 1'b1;
      if (w_push && !w_pop)      r_fill <= r_fill + 1'b1;
      else if (!w_push && w_pop) r_fill <= r_fill - 1'b1;
    end
  end

  // Head entry is masked while empty so the unreset storage never leaks to the outputs.
  assign bus.rsp_valid   = (r_fill != '0);
  assign bus.rsp_id      = bus.rsp_valid ? r_mem[r_rd].id[ID_W-1:0] : '0;
  assign bus.rsp_product = bus.rsp_valid ? r_mem[r_rd].product : '0;
  assign bus.busy        = (r_cnt != '0);

endmodule
